// File: rtl/usb_hub_tx_scheduler_pkg.sv
// Shared types and helpers for the hub transmit scheduler and its round-robin arbiter.
package usb_hub_tx_scheduler_pkg;

  localparam int unsigned USB_SCHED_STATE_WIDTH = 3;

  typedef enum logic [USB_SCHED_STATE_WIDTH-1:0] {
    SCHED_IDLE      = 3'd0,
    SCHED_ARB       = 3'd1,
    SCHED_START     = 3'd2,
    SCHED_DRIVE     = 3'd3,
    SCHED_WAIT_RESP = 3'd4,
    SCHED_RECV      = 3'd5,
    SCHED_DONE      = 3'd6
  } sched_state_t;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/usb_hub_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting port after last_grant, with wrap-around.
module usb_rr_arbiter
  import usb_hub_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W    = cnt_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant
);

  int unsigned w_idx;
  logic        w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      w_idx = (32'(last_grant) + k) % NUM_PORTS;
      if (!w_found && ((req & (NUM_PORTS'(1) << w_idx)) != '0)) begin
        grant   = NUM_PORTS'(1) << w_idx;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_hub_tx_scheduler.sv
// Hub transceiver scheduler: arbitrates ports against a periodic poll slot and tracks
// each transaction through drive, response wait and receive.
module usb_hub_tx_scheduler
  import usb_hub_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned POLL_PERIOD  = 1000,
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] port_req,
  output logic [NUM_PORTS-1:0] port_grant,
  output logic                 port_done,
  output logic                 port_timeout,
  output logic                 poll_start,
  output logic                 data_start,
  input  logic                 tr_driving,
  input  logic                 rx_val,
  output logic                 busy
);

  localparam int unsigned IDX_W  = cnt_width(NUM_PORTS);
  localparam int unsigned POLL_W = cnt_width(POLL_PERIOD);
  localparam int unsigned TO_W   = cnt_width(RESP_TIMEOUT);
  localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_RELOAD   = TO_W'(RESP_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_RESET  = IDX_W'(NUM_PORTS - 1);

  sched_state_t         r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [IDX_W-1:0]     r_last_grant;
  logic [POLL_W-1:0]    r_poll_cnt;
  logic                 r_poll_pending;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_quiet;
  logic                 r_poll_start;
  logic                 r_data_start;
  logic                 r_done;
  logic                 r_timeout;

  logic                 w_poll_zero;
  logic                 w_poll_take;
  logic [NUM_PORTS-1:0] w_arb_grant;
  logic [IDX_W-1:0]     w_arb_idx;

  usb_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .req        (port_req),
    .last_grant (r_last_grant),
    .grant      (w_arb_grant)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_arb_grant[i]) w_arb_idx = IDX_W'(i);
    end
  end

  // An expiry seen directly in IDLE is taken that same cycle without waiting for the latch.
  assign w_poll_zero = (r_poll_cnt == '0);
  assign w_poll_take = (r_state == SCHED_IDLE) && (r_poll_pending || w_poll_zero);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_poll_cnt     <= POLL_RELOAD;
      r_poll_pending <= 1'b0;
    end else begin
      r_poll_cnt <= w_poll_zero ? POLL_RELOAD : r_poll_cnt - POLL_W'(1);
      if (w_poll_take)      r_poll_pending <= 1'b0;
      else if (w_poll_zero) r_poll_pending <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= SCHED_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_RESET;
      r_to_cnt     <= '0;
      r_quiet      <= 1'b0;
      r_poll_start <= 1'b0;
      r_data_start <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_poll_start <= 1'b0;
      r_data_start <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        SCHED_IDLE: begin
          if (w_poll_take) begin
            r_state      <= SCHED_START;
            r_poll_start <= 1'b1;
            r_to_cnt     <= TO_RELOAD;
          end else if (|port_req) begin
            r_state <= SCHED_ARB;
          end
        end
        SCHED_ARB: begin
          // A request withdrawn before arbitration simply returns to IDLE.
          if (|w_arb_grant) begin
            r_state      <= SCHED_START;
            r_grant      <= w_arb_grant;
            r_last_grant <= w_arb_idx;
            r_data_start <= 1'b1;
            r_to_cnt     <= TO_RELOAD;
          end else begin
            r_state <= SCHED_IDLE;
          end
        end
        SCHED_START: begin
          if (tr_driving) begin
            r_state <= SCHED_DRIVE;
          end else if (r_to_cnt == '0) begin
            r_state   <= SCHED_DONE;
            r_done    <= |r_grant;
            r_timeout <= |r_grant;
          end else begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
          end
        end
        SCHED_DRIVE: begin
          if (!tr_driving) begin
            r_state  <= SCHED_WAIT_RESP;
            r_to_cnt <= TO_RELOAD;
          end
        end
        SCHED_WAIT_RESP: begin
          if (rx_val) begin
            r_state <= SCHED_RECV;
            r_quiet <= 1'b0;
          end else if (r_to_cnt == '0) begin
            r_state   <= SCHED_DONE;
            r_done    <= |r_grant;
            r_timeout <= |r_grant;
          end else begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
          end
        end
        SCHED_RECV: begin
          if (rx_val) begin
            r_quiet <= 1'b0;
          end else if (r_quiet) begin
            r_state <= SCHED_DONE;
            r_done  <= |r_grant;
          end else begin
            r_quiet <= 1'b1;
          end
        end
        SCHED_DONE: begin
          r_state <= SCHED_IDLE;
          r_grant <= '0;
        end
        default: r_state <= SCHED_IDLE;
      endcase
    end
  end

  assign port_grant   = r_grant;
  assign port_done    = r_done;
  assign port_timeout = r_timeout;
  assign poll_start   = r_poll_start;
  assign data_start   = r_data_start;
  assign busy         = (r_state != SCHED_IDLE);

endmodule

// File: tb/tb_usb_hub_tx_scheduler.sv
// Directed bench for usb_hub_tx_scheduler with POLL_PERIOD=16 and RESP_TIMEOUT=4.
module tb_usb_hub_tx_scheduler;

  localparam int unsigned NP = 4;
  localparam int unsigned PP = 16;
  localparam int unsigned RT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] port_req = '0;
  logic          tr_driving = 1'b0;
  logic          rx_val = 1'b0;
  logic [NP-1:0] port_grant;
  logic          port_done;
  logic          port_timeout;
  logic          poll_start;
  logic          data_start;
  logic          busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned n;
  logic [NP-1:0] exp_grant [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};

  always #5 clock = ~clock;

  usb_hub_tx_scheduler #(
    .NUM_PORTS    (NP),
    .POLL_PERIOD  (PP),
    .RESP_TIMEOUT (RT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .port_req     (port_req),
    .port_grant   (port_grant),
    .port_done    (port_done),
    .port_timeout (port_timeout),
    .poll_start   (poll_start),
    .data_start   (data_start),
    .tr_driving   (tr_driving),
    .rx_val       (rx_val),
    .busy         (busy)
  );

  task automatic tick(input int unsigned cnt);
    repeat (cnt) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_data_start(input int unsigned max, output int unsigned cnt);
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (!data_start && cnt < max);
  endtask

  task automatic wait_done(input int unsigned max, output int unsigned cnt);
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (!port_done && cnt < max);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values, and no poll pulse while reset is held past a full period.
    tick(3);
    chk("rst_grant", 32'(port_grant), 0);
    chk("rst_done", 32'(port_done), 0);
    chk("rst_timeout", 32'(port_timeout), 0);
    chk("rst_data_start", 32'(data_start), 0);
    chk("rst_busy", 32'(busy), 0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("rst_poll", 32'(poll_start), 0);
    end

    // Idle poll cadence: first pulse 16 cycles after release, then every 16.
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk("poll_first", 32'(poll_start), 32'(k == 16));
    end
    chk("poll_busy", 32'(busy), 1);
    chk("poll_no_grant", 32'(port_grant), 0);
    tick(1);
    chk("poll_pulse_once", 32'(poll_start), 0);
    for (int k = 2; k <= 16; k++) begin
      tick(1);
      chk("poll_period", 32'(poll_start), 32'(k == 16));
      chk("poll_no_done", 32'(port_done), 0);
      if (k == 5) chk("poll_slot_end_idle", 32'(busy), 0);
    end

    // Port 1 handshake starting in IDLE 5 cycles after the poll START.
    tick(5);
    chk("hs_idle", 32'(busy), 0);
    port_req = 4'b0010;
    tick(1);
    chk("hs_arb_busy", 32'(busy), 1);
    chk("hs_arb_nogrant", 32'(port_grant), 0);
    chk("hs_arb_nostart", 32'(data_start), 0);
    tick(1);
    chk("hs_grant", 32'(port_grant), 32'h2);
    chk("hs_data_start", 32'(data_start), 1);
    tr_driving = 1'b1;
    tick(1);
    chk("hs_data_start_once", 32'(data_start), 0);
    port_req = '0;
    tick(19);
    chk("hs_grant_held", 32'(port_grant), 32'h2);
    tr_driving = 1'b0;
    tick(1);
    rx_val = 1'b1;
    tick(8);
    rx_val = 1'b0;
    tick(1);
    chk("hs_no_early_done", 32'(port_done), 0);
    tick(1);
    chk("hs_done", 32'(port_done), 1);
    chk("hs_no_timeout", 32'(port_timeout), 0);
    chk("hs_done_grant", 32'(port_grant), 32'h2);
    port_req = 4'b0001;

    // Poll expired during the transaction: it wins over the held port 0 request.
    tick(1);
    chk("col_idle", 32'(busy), 0);
    chk("col_grant_clear", 32'(port_grant), 0);
    chk("col_done_pulse", 32'(port_done), 0);
    tick(1);
    chk("col_poll_first", 32'(poll_start), 1);
    chk("col_poll_nogrant", 32'(port_grant), 0);
    chk("col_poll_nodata", 32'(data_start), 0);
    wait_data_start(40, n);
    chk("col_port_seen", 32'(data_start), 1);
    chk("col_port_grant", 32'(port_grant), 32'h1);

    // Reset while receiving, then round-robin restarts at port 0.
    tr_driving = 1'b1;
    tick(2);
    tr_driving = 1'b0;
    tick(1);
    rx_val = 1'b1;
    tick(1);
    chk("mid_recv_busy", 32'(busy), 1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_grant", 32'(port_grant), 0);
    chk("mid_rst_done", 32'(port_done), 0);
    chk("mid_rst_timeout", 32'(port_timeout), 0);
    reset = 1'b0;
    rx_val = 1'b0;
    port_req = 4'b0011;
    tick(1);
    chk("mid_rst_no_done", 32'(port_done), 0);
    tick(1);
    chk("rr_restart_start", 32'(data_start), 1);
    chk("rr_restart_grant", 32'(port_grant), 32'(exp_grant[0]));

    // Fairness with all ports requesting; every transaction times out in START.
    port_req = 4'b1111;
    for (int i = 1; i < 8; i++) begin
      wait_data_start(60, n);
      chk("rr_seen", 32'(data_start), 1);
      chk("rr_grant", 32'(port_grant), 32'(exp_grant[i]));
    end
    port_req = 4'b0100;

    // No drive: timeout exactly RESP_TIMEOUT cycles after START.
    wait_data_start(60, n);
    chk("to_start_seen", 32'(data_start), 1);
    chk("to_start_grant", 32'(port_grant), 32'h4);
    port_req = '0;
    wait_done(20, n);
    chk("to_start_cycles", n, RT);
    chk("to_start_flag", 32'(port_timeout), 1);
    chk("to_start_grant_held", 32'(port_grant), 32'h4);
    tick(1);
    chk("to_start_after_done", 32'(port_done), 0);
    chk("to_start_after_grant", 32'(port_grant), 0);
    chk("to_start_after_busy", 32'(busy), 0);

    // Drive seen on the expiry cycle succeeds; no response then times out.
    port_req = 4'b1000;
    wait_data_start(60, n);
    chk("to_resp_seen", 32'(data_start), 1);
    chk("to_resp_grant", 32'(port_grant), 32'h8);
    port_req = '0;
    tick(RT - 1);
    tr_driving = 1'b1;
    tick(1);
    chk("edge_drive_no_done", 32'(port_done), 0);
    chk("edge_drive_busy", 32'(busy), 1);
    tick(10);
    chk("drive_no_timeout", 32'(busy), 1);
    chk("drive_no_done", 32'(port_done), 0);
    tr_driving = 1'b0;
    wait_done(20, n);
    chk("to_resp_cycles", n, RT + 1);
    chk("to_resp_flag", 32'(port_timeout), 1);
    chk("to_resp_grant_held", 32'(port_grant), 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
